// File: rtl/digit_scan_controller.sv
// Scans NUM_DIGITS code registers through one shared segment decoder, with a
// blanking gap before each digit and a registered segment/enable pair to the pads.
module digit_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int CODE_W       = 8,
    parameter int DWELL_W      = 10,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ena_i,
    input  logic                  wr_en_i,
    input  logic [2:0]            wr_addr_i,
    input  logic [CODE_W-1:0]     wr_data_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    output logic [CODE_W-1:0]     dec_code_o,
    input  logic [CODE_W-1:0]     dec_seg_i,
    output logic [CODE_W-1:0]     seg_out_o,
    output logic [NUM_DIGITS-1:0] digit_en_o,
    output logic                  frame_tick_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        LOAD  = 2'd2,
        SHOW  = 2'd3
    } state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DWELL_W-1:0]    cnt_q;
    logic [CODE_W-1:0]     seg_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  tick_q;

    logic [CODE_W-1:0]     digit_reg_q [NUM_DIGITS];
    logic [CODE_W-1:0]     digit_reg_d [NUM_DIGITS];
    logic [CODE_W-1:0]     cur_code;
    logic [DWELL_W:0]      cnt_p1;
    logic                  blank_done;
    logic                  show_done;
    logic                  last_digit;

    // Out-of-range addresses match no entry and so are dropped.
    always_comb begin
        digit_reg_d = digit_reg_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en_i && (wr_addr_i == 3'(i))) begin
                digit_reg_d[i] = wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg_q[i] <= '0;
            end
        end else begin
            digit_reg_q <= digit_reg_d;
        end
    end

    always_comb begin
        cur_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = digit_reg_q[i];
            end
        end
    end

    assign dec_code_o = (state_q == IDLE) ? '0 : cur_code;

    // SHOW ends once cnt+1 reaches the live dwell; dwell=0 therefore ends at once.
    assign cnt_p1     = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
    assign show_done  = (cnt_p1 >= {1'b0, dwell_i});
    assign blank_done = (cnt_q == DWELL_W'(BLANK_CYCLES - 1));
    assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= '0;
            en_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ena_i) begin
                        state_q <= BLANK;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                BLANK: begin
                    if (blank_done) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + DWELL_W'(1);
                    end
                end
                LOAD: begin
                    state_q <= SHOW;
                    cnt_q   <= '0;
                    seg_q   <= dec_seg_i;
                    en_q    <= NUM_DIGITS'(1) << idx_q;
                end
                SHOW: begin
                    if (show_done) begin
                        state_q <= BLANK;
                        cnt_q   <= '0;
                        seg_q   <= '0;
                        en_q    <= '0;
                        idx_q   <= last_digit ? '0 : idx_q + IDX_W'(1);
                        tick_q  <= last_digit;
                    end else begin
                        cnt_q <= cnt_q + DWELL_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Dropping enable abandons the partial frame from any active state.
            if ((state_q != IDLE) && !ena_i) begin
                state_q <= IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
                seg_q   <= '0;
                en_q    <= '0;
                tick_q  <= 1'b0;
            end
        end
    end

    assign seg_out_o    = seg_q;
    assign digit_en_o   = en_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Bench for digit_scan_controller: directed steps plus a random phase, every cycle
// checked against a period-position model with the decoder modelled as ~code.
module tb_digit_scan_controller;

    localparam int N = 4;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] dwell;
    logic [7:0] dec_code;
    logic [7:0] dec_seg;
    logic [7:0] seg_out;
    logic [3:0] digit_en;
    logic       frame_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cur      = -1;

    // Model: active flag, digit index, position within the digit period.
    bit         m_act;
    int         m_idx;
    int         m_pos;
    bit         m_tick;
    logic [7:0] m_seg;
    logic [7:0] m_regs [N];

    digit_scan_controller #(
        .NUM_DIGITS(N), .CODE_W(8), .DWELL_W(10), .BLANK_CYCLES(B)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .dwell_i(dwell),
        .dec_code_o(dec_code), .dec_seg_i(dec_seg), .seg_out_o(seg_out),
        .digit_en_o(digit_en), .frame_tick_o(frame_tick)
    );

    assign dec_seg = ~dec_code;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cur);
        end
    endtask

    task automatic model_step();
        int d;
        if (!rst_n) begin
            m_act = 0; m_idx = 0; m_pos = 0; m_tick = 0; m_seg = '0;
            for (int i = 0; i < N; i++) m_regs[i] = '0;
        end else begin
            m_tick = 0;
            d = (dwell == 0) ? 1 : int'(dwell);
            if (!m_act) begin
                if (ena) begin m_act = 1; m_idx = 0; m_pos = 0; end
            end else if (!ena) begin
                m_act = 0; m_idx = 0; m_pos = 0; m_seg = '0;
            end else if (m_pos < B) begin
                m_pos++;
            end else if (m_pos == B) begin
                m_seg = ~m_regs[m_idx];
                m_pos++;
            end else if ((m_pos - B) >= d) begin
                m_tick = (m_idx == N - 1);
                m_idx  = (m_idx + 1) % N;
                m_pos  = 0;
                m_seg  = '0;
            end else begin
                m_pos++;
            end
            if (wr_en && (int'(wr_addr) < N)) m_regs[wr_addr] = wr_data;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_dec, e_seg;
        logic [3:0] e_en;
        logic       e_tick;
        bit         showing;
        showing = m_act && (m_pos > B);
        e_dec   = m_act ? m_regs[m_idx] : 8'h00;
        e_seg   = showing ? m_seg : 8'h00;
        e_en    = showing ? (4'b0001 << m_idx) : 4'b0000;
        e_tick  = m_act && (m_pos == 0) && m_tick;
        chk("dec_code", 32'(dec_code), 32'(e_dec));
        chk("seg_out", 32'(seg_out), 32'(e_seg));
        chk("digit_en", 32'(digit_en), 32'(e_en));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        chk("onehot0", 32'($onehot0(digit_en)), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cur++;
        check_outputs();
    endtask

    task automatic run_to(input int t);
        while (cur < t) tick();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; dwell = 10'd3;

        // Reset, then idle with enable low.
        tick(); tick();
        chk("rst_seg", 32'(seg_out), 32'h0);
        chk("rst_en", 32'(digit_en), 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_dec", 32'(dec_code), 32'h0);
        chk("idle_tick", 32'(frame_tick), 32'h0);

        // Load codes 0x11..0x44.
        wr_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            wr_addr = 3'(i);
            wr_data = 8'(8'h11 * (i + 1));
            tick();
        end
        wr_en = 1'b0;

        // Basic scan, dwell 3, period 6, frame 24.
        ena = 1'b1; cur = -1;
        tick();
        chk("start_notick", 32'(frame_tick), 32'h0);
        run_to(3);  chk("d0_en", 32'(digit_en), 32'h1); chk("d0_seg", 32'(seg_out), 32'hEE);
        run_to(6);  chk("gap_en", 32'(digit_en), 32'h0);
        run_to(9);  chk("d1_en", 32'(digit_en), 32'h2); chk("d1_seg", 32'(seg_out), 32'hDD);
        run_to(15); chk("d2_seg", 32'(seg_out), 32'hCC);
        run_to(21); chk("d3_seg", 32'(seg_out), 32'hBB);
        run_to(23); chk("tick23", 32'(frame_tick), 32'h0);
        run_to(24); chk("tick24", 32'(frame_tick), 32'h1);

        // Write digit 1 while it is showing.
        run_to(33);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        chk("midwr_hold", 32'(seg_out), 32'hDD);
        run_to(35); chk("midwr_hold2", 32'(seg_out), 32'hDD);
        run_to(48); chk("tick48", 32'(frame_tick), 32'h1);
        run_to(57); chk("midwr_new", 32'(seg_out), 32'hA5);

        // Stop, then dwell=0 restart: period 4, frame 16.
        ena = 1'b0;
        tick();
        chk("stop_en", 32'(digit_en), 32'h0);
        dwell = 10'd0; ena = 1'b1; cur = -1;
        tick();
        chk("restart_notick", 32'(frame_tick), 32'h0);
        run_to(3);  chk("dw0_d0", 32'(digit_en), 32'h1);
        run_to(4);  chk("dw0_gap", 32'(digit_en), 32'h0);
        run_to(7);  chk("dw0_d1", 32'(digit_en), 32'h2);
        run_to(11); chk("dw0_d2", 32'(digit_en), 32'h4);

        // Abort during digit 2.
        ena = 1'b0;
        tick();
        chk("abort_en", 32'(digit_en), 32'h0);
        chk("abort_seg", 32'(seg_out), 32'h0);
        ena = 1'b1; cur = -1;
        tick();
        chk("reabort_notick", 32'(frame_tick), 32'h0);
        run_to(3);  chk("restart_d0", 32'(digit_en), 32'h1);
        run_to(15); chk("dw0_d3", 32'(digit_en), 32'h8);
        run_to(16); chk("dw0_tick16", 32'(frame_tick), 32'h1);

        // Dwell lowered from 10 to 2 at SHOW counter 5.
        dwell = 10'd10;
        run_to(24); chk("long_show", 32'(digit_en), 32'h1);
        dwell = 10'd2;
        tick();
        chk("dwell_cut", 32'(digit_en), 32'h0);
        run_to(29); chk("dw2_d1", 32'(digit_en), 32'h2);
        run_to(30); chk("dw2_end", 32'(digit_en), 32'h0);

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            if ($urandom_range(0, 15) == 0) dwell = 10'($urandom_range(0, 5));
            ena = ($urandom_range(0, 49) != 0);
            tick();
        end
        wr_en = 1'b0; ena = 1'b1; dwell = 10'd3;

        // Reset during SHOW clears outputs and code registers.
        for (int i = 0; i < 60; i++) begin
            if (m_act && (m_pos > B)) break;
            tick();
        end
        chk("pre_rst_show", 32'(digit_en != 4'h0), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("midrst_seg", 32'(seg_out), 32'h0);
        chk("midrst_en", 32'(digit_en), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_clear_dec", 32'(dec_code), 32'h0);

        // Out-of-range writes must leave every register at zero.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hFF;
        tick();
        wr_addr = 3'd4; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("badaddr_dec", 32'(dec_code), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_controller.md
Name: digit_scan_controller

Overview:
- Time-multiplexes one shared combinational character/segment decoder across NUM_DIGITS display positions.
- Holds one code register per digit and presents the current digit's code to the decoder.
- Registers the decoder's segment output and drives a one-hot digit enable.
- Inserts a blanking gap between digits to prevent ghosting; sits between the top-level I/O pins and the decoder instance.

Parameters:
NUM_DIGITS, 4, number of scanned positions (2..8)
CODE_W, 8, width of a digit code and of the decoder segment bus
DWELL_W, 10, width of the dwell input and the dwell counter
BLANK_CYCLES, 2, blanking cycles before each digit (legal 1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
ena  in  1  scan enable; low forces IDLE
wr_en  in  1  write strobe for digit code registers
wr_addr  in  3  digit index to write
wr_data  in  CODE_W  code written to digit_reg[wr_addr]
dwell  in  DWELL_W  SHOW length in cycles (0 treated as 1)
dec_code  out  CODE_W  code driven to the shared decoder
dec_seg  in  CODE_W  decoder result (combinational from dec_code)
seg_out  out  CODE_W  registered segment pattern to pads
digit_en  out  NUM_DIGITS  one-hot active-high digit select
frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE; idx=0; counter=0.
  - All digit_reg=0; seg_out=0; digit_en=0; frame_tick=0.
  - Reset wins over every other event in the same cycle.
- dec_code: equals digit_reg[idx] in every state except IDLE, where it is 0.
- States:
  - IDLE: seg_out=0, digit_en=0. If ena=1 is sampled, next state is BLANK with idx=0 and counter=0.
  - BLANK: seg_out=0, digit_en=0. Lasts exactly BLANK_CYCLES cycles (counter 0..BLANK_CYCLES-1), then goes to LOAD.
  - LOAD: one cycle; digit_en=0. At the closing edge, seg_out<=dec_seg.
  - SHOW:
    - digit_en=1<<idx; seg_out held.
    - Lasts max(dwell,1) cycles; counter compares against the live dwell value.
    - If dwell is lowered so that counter >= dwell-1, SHOW ends at the next edge.
    - On exit: idx<=(idx==NUM_DIGITS-1)?0:idx+1, then go to BLANK.
- Timing:
  - Per-digit period = BLANK_CYCLES+1+max(dwell,1) cycles.
  - Frame = NUM_DIGITS times that period.
  - seg_out is valid for exactly the cycles in which digit_en is nonzero.
- frame_tick:
  - Asserted only in the first BLANK cycle after idx wraps from NUM_DIGITS-1 to 0.
  - Not asserted on the initial start from IDLE.
- ena=0 sampled in any non-IDLE state: next cycle is IDLE; seg_out=0, digit_en=0, idx=0. The partial frame is discarded.
- Writes:
  - Accepted in any state, including IDLE; take effect at the next clk edge.
  - wr_addr>=NUM_DIGITS is ignored.
  - A write to the digit currently in SHOW does not change seg_out. The new code appears on that digit's next LOAD.
  - A write during BLANK/LOAD of the same digit is visible on dec_code immediately. It is captured if it lands before the LOAD edge.
- Invariants:
  - digit_en is never multi-hot.
  - digit_en and a nonzero seg_out never coexist outside SHOW.

Test Plan:
- Reset then idle: rst_n low 2 cycles, ena=0 -> seg_out=0, digit_en=0, dec_code=0, frame_tick=0 indefinitely.
- Basic scan:
  - Setup: codes 0x11,0x22,0x33,0x44 written to idx 0..3; dwell=3; BLANK_CYCLES=2; decoder modelled as dec_seg=~dec_code; ena=1.
  - Required: digit_en sequence 0001,0010,0100,1000 each for 3 cycles, 3 blank cycles between digits, period 6.
  - Required: seg_out=0xEE,0xDD,0xCC,0xBB during the respective SHOW windows.
  - Required: frame_tick 1 cycle at cycle 24 after BLANK entry, then every 24 cycles.
- Mid-display write: while digit 1 is in SHOW, write 0x5A to idx 1 -> seg_out stays 0xDD for that window; next frame shows 0xA5 on digit 1.
- Dwell edge cases:
  - dwell=0 -> SHOW lasts 1 cycle, period 4.
  - Changing dwell from 10 to 2 at SHOW counter 5 -> SHOW ends at the next edge.
- Abort: drop ena during digit 2 SHOW -> next cycle digit_en=0, seg_out=0.
  - Re-raise ena -> restart at digit 0 with no frame_tick on restart.
- Reset mid-scan and bad address:
  - rst_n low during SHOW -> all outputs 0 next edge; digit_regs cleared (dec_code=0 on restart scan).
  - wr_addr=5 write with NUM_DIGITS=4 -> no register changes.
